// File: rtl/midi_parser_pkg.sv
// Shared MIDI definitions: event encoding, status nibbles, parser states.
package MIDI;

    localparam int BAUD_RATE = 31250;

    // Decoded channel-voice event kinds. Literals carry an EV_ prefix so they
    // do not collide with the status-nibble constants of the same name.
    typedef enum logic [1:0] {
        EV_NOTE_ON    = 2'd0,
        EV_NOTE_OFF   = 2'd1,
        EV_CONTROL    = 2'd2,
        EV_PITCH_BEND = 2'd3
    } event_t;

    // Parser FSM states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_D1 = 2'd1,
        WAIT_D2 = 2'd2
    } state_t;

    // Upper nibble of channel status bytes.
    localparam logic [3:0] NOTE_OFF = 4'h8;
    localparam logic [3:0] NOTE_ON  = 4'h9;
    localparam logic [3:0] POLY_AT  = 4'hA;
    localparam logic [3:0] CC       = 4'hB;
    localparam logic [3:0] PROG     = 4'hC;
    localparam logic [3:0] CHAN_AT  = 4'hD;
    localparam logic [3:0] BEND     = 4'hE;

    // Number of data bytes that follow a channel status nibble.
    function automatic logic [1:0] data_len(input logic [3:0] status);
        if (status == PROG || status == CHAN_AT) begin
            return 2'd1;
        end
        return 2'd2;
    endfunction

endpackage

// File: rtl/midi_parser.sv
// Byte-level MIDI parser: tracks running status and emits one registered
// channel-voice event per complete message.
//
// Handshake: data_in is sampled on every clock edge where data_in_ready is
// high; there is no ready/backpressure, so every strobe is one byte and
// event_valid is a one-cycle pulse with no acknowledge.
module midi_parser
    import MIDI::*;
#(
    parameter bit         OMNI    = 1'b1,
    parameter logic [3:0] CHANNEL = 4'h0
) (
    input  logic       clock_50_000_000,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       data_in_ready,
    output logic       event_valid,
    output logic [1:0] event_type,
    output logic [3:0] event_channel,
    output logic [6:0] event_key,
    output logic [6:0] event_value,
    output logic [7:0] stray_count,
    output logic [1:0] debug_state
);

    state_t      state_q,  state_d;
    logic [7:0]  status_q, status_d;
    logic [6:0]  d1_q,     d1_d;
    logic [7:0]  stray_q,  stray_d;
    logic        valid_q,  valid_d;
    logic [1:0]  type_q,   type_d;
    logic [3:0]  chan_q,   chan_d;
    logic [6:0]  key_q,    key_d;
    logic [6:0]  value_q,  value_d;
    logic        complete;

    // Byte classification and FSM next state; realtime bytes fall through untouched.
    always_comb begin
        state_d  = state_q;
        status_d = status_q;
        d1_d     = d1_q;
        stray_d  = stray_q;
        complete = 1'b0;
        if (data_in_ready) begin
            if (data_in[7]) begin
                if (data_in[7:4] != 4'hF) begin
                    status_d = data_in;
                    state_d  = WAIT_D1;
                end else if (!data_in[3]) begin
                    status_d = 8'h00;
                    state_d  = IDLE;
                end
            end else begin
                case (state_q)
                    IDLE: begin
                        if (stray_q != 8'hFF) begin
                            stray_d = stray_q + 8'd1;
                        end
                    end
                    WAIT_D1: begin
                        if (data_len(status_q[7:4]) == 2'd1) begin
                            complete = 1'b1;
                        end else begin
                            d1_d    = data_in[6:0];
                            state_d = WAIT_D2;
                        end
                    end
                    WAIT_D2: begin
                        complete = 1'b1;
                        state_d  = WAIT_D1;
                    end
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    // Map a completed message to an event; fields only move when an event fires.
    always_comb begin
        logic       emit;
        logic [1:0] kind;
        logic [6:0] key;
        emit    = 1'b0;
        kind    = EV_NOTE_ON;
        key     = (state_q == WAIT_D2) ? d1_q : data_in[6:0];
        valid_d = 1'b0;
        type_d  = type_q;
        chan_d  = chan_q;
        key_d   = key_q;
        value_d = value_q;
        if (complete) begin
            case (status_q[7:4])
                NOTE_ON: begin
                    emit = 1'b1;
                    kind = (data_in[6:0] != 7'd0) ? EV_NOTE_ON : EV_NOTE_OFF;
                end
                NOTE_OFF: begin
                    emit = 1'b1;
                    kind = EV_NOTE_OFF;
                end
                CC: begin
                    emit = 1'b1;
                    kind = EV_CONTROL;
                end
                BEND: begin
                    emit = 1'b1;
                    kind = EV_PITCH_BEND;
                end
                default: emit = 1'b0;
            endcase
            if (emit && (OMNI || status_q[3:0] == CHANNEL)) begin
                valid_d = 1'b1;
                type_d  = kind;
                chan_d  = status_q[3:0];
                key_d   = key;
                value_d = data_in[6:0];
            end
        end
    end

    // State, latches, counter and registered event outputs.
    always_ff @(posedge clock_50_000_000) begin
        if (reset) begin
            state_q  <= IDLE;
            status_q <= 8'h00;
            d1_q     <= 7'd0;
            stray_q  <= 8'd0;
            valid_q  <= 1'b0;
            type_q   <= 2'd0;
            chan_q   <= 4'd0;
            key_q    <= 7'd0;
            value_q  <= 7'd0;
        end else begin
            state_q  <= state_d;
            status_q <= status_d;
            d1_q     <= d1_d;
            stray_q  <= stray_d;
            valid_q  <= valid_d;
            type_q   <= type_d;
            chan_q   <= chan_d;
            key_q    <= key_d;
            value_q  <= value_d;
        end
    end

    assign event_valid   = valid_q;
    assign event_type    = type_q;
    assign event_channel = chan_q;
    assign event_key     = key_q;
    assign event_value   = value_q;
    assign stray_count   = stray_q;
    assign debug_state   = state_q;

endmodule

// File: tb/tb_midi_parser.sv
// Directed bench for midi_parser: byte-vector table plus hand sequences for
// back-to-back strobes, counter saturation and reset collision.
module tb_midi_parser;

    logic       clk;
    logic       rst;
    logic [7:0] din;
    logic       rdy;

    logic       a_v, b_v;
    logic [1:0] a_t, b_t;
    logic [3:0] a_c, b_c;
    logic [6:0] a_k, b_k, a_val, b_val;
    logic [7:0] a_s, b_s;
    logic [1:0] a_dbg, b_dbg;

    int checks = 0;
    int errors = 0;

    midi_parser #(.OMNI(1'b1), .CHANNEL(4'h0)) dut_a (
        .clock_50_000_000(clk), .reset(rst), .data_in(din), .data_in_ready(rdy),
        .event_valid(a_v), .event_type(a_t), .event_channel(a_c),
        .event_key(a_k), .event_value(a_val), .stray_count(a_s), .debug_state(a_dbg)
    );

    midi_parser #(.OMNI(1'b0), .CHANNEL(4'h2)) dut_b (
        .clock_50_000_000(clk), .reset(rst), .data_in(din), .data_in_ready(rdy),
        .event_valid(b_v), .event_type(b_t), .event_channel(b_c),
        .event_key(b_k), .event_value(b_val), .stray_count(b_s), .debug_state(b_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [7:0] b;
        logic       sel;
        logic       v;
        logic [1:0] t;
        logic [3:0] c;
        logic [6:0] k;
        logic [6:0] val;
        logic [7:0] stray;
    } vec_t;

    vec_t vecs[$];

    // last expected event fields per DUT (fields hold between pulses)
    logic [1:0] last_t[2];
    logic [3:0] last_c[2];
    logic [6:0] last_k[2];
    logic [6:0] last_val[2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic [7:0] b, input logic s, input logic v,
                       input logic [1:0] t, input logic [3:0] c, input logic [6:0] k,
                       input logic [6:0] val, input logic [7:0] stray);
        vec_t x;
        x.rst = r; x.b = b; x.sel = s; x.v = v; x.t = t; x.c = c; x.k = k; x.val = val;
        x.stray = stray;
        vecs.push_back(x);
    endtask

    task automatic clear_last();
        for (int i = 0; i < 2; i++) begin
            last_t[i] = 2'd0; last_c[i] = 4'd0; last_k[i] = 7'd0; last_val[i] = 7'd0;
        end
    endtask

    // driver: called at a negedge, returns at a negedge
    task automatic do_reset();
        rst = 1'b1; rdy = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        clear_last();
    endtask

    task automatic send_byte(input logic [7:0] b);
        din = b; rdy = 1'b1;
        @(negedge clk);
        rdy = 1'b0;
    endtask

    task automatic check_sel(input string tag, input logic s, input logic v, input logic [1:0] t,
                             input logic [3:0] c, input logic [6:0] k, input logic [6:0] val,
                             input logic [7:0] stray);
        int i;
        i = s ? 1 : 0;
        chk({tag, " valid"}, s ? b_v : a_v, v);
        if (v) begin
            last_t[i] = t; last_c[i] = c; last_k[i] = k; last_val[i] = val;
        end
        chk({tag, " type"},  s ? b_t : a_t, last_t[i]);
        chk({tag, " chan"},  s ? b_c : a_c, last_c[i]);
        chk({tag, " key"},   s ? b_k : a_k, last_k[i]);
        chk({tag, " value"}, s ? b_val : a_val, last_val[i]);
        chk({tag, " stray"}, s ? b_s : a_s, stray);
    endtask

    logic [7:0] burst[5];
    logic       burst_v[5];

    initial begin
        rst = 1'b0; din = 8'h00; rdy = 1'b0;
        clear_last();
        @(negedge clk);
        do_reset();

        // reset state
        check_sel("reset_a", 1'b0, 1'b0, 2'd0, 4'd0, 7'd0, 7'd0, 8'd0);
        check_sel("reset_b", 1'b1, 1'b0, 2'd0, 4'd0, 7'd0, 7'd0, 8'd0);
        chk("reset_state", a_dbg, 2'd0);

        // table: rst, byte, sel, valid, type, chan, key, value, stray
        add(1, 8'h00, 0, 0, 0, 0, 0, 0, 0);
        add(0, 8'h90, 0, 0, 0, 0, 0, 0, 0);
        add(0, 8'h3C, 0, 0, 0, 0, 0, 0, 0);
        add(0, 8'h64, 0, 1, 2'd0, 4'h0, 7'h3C, 7'h64, 0);
        add(0, 8'h93, 0, 0, 0, 0, 0, 0, 0);
        add(0, 8'h40, 0, 0, 0, 0, 0, 0, 0);
        add(0, 8'h7F, 0, 1, 2'd0, 4'h3, 7'h40, 7'h7F, 0);
        add(0, 8'h40, 0, 0, 0, 0, 0, 0, 0);
        add(0, 8'h00, 0, 1, 2'd1, 4'h3, 7'h40, 7'h00, 0);
        add(0, 8'hB1, 0, 0, 0, 0, 0, 0, 0);
        add(0, 8'hF8, 0, 0, 0, 0, 0, 0, 0);
        add(0, 8'h07, 0, 0, 0, 0, 0, 0, 0);
        add(0, 8'hFE, 0, 0, 0, 0, 0, 0, 0);
        add(0, 8'h55, 0, 1, 2'd2, 4'h1, 7'h07, 7'h55, 0);
        add(0, 8'h80, 0, 0, 0, 0, 0, 0, 0);
        add(0, 8'h40, 0, 0, 0, 0, 0, 0, 0);
        add(0, 8'h22, 0, 1, 2'd1, 4'h0, 7'h40, 7'h22, 0);
        add(0, 8'hC5, 0, 0, 0, 0, 0, 0, 0);
        add(0, 8'h10, 0, 0, 0, 0, 0, 0, 0);
        add(0, 8'h11, 0, 0, 0, 0, 0, 0, 0);
        add(0, 8'hA0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 8'h01, 0, 0, 0, 0, 0, 0, 0);
        add(0, 8'h02, 0, 0, 0, 0, 0, 0, 0);
        add(0, 8'hE7, 0, 0, 0, 0, 0, 0, 0);
        add(0, 8'h01, 0, 0, 0, 0, 0, 0, 0);
        add(0, 8'h02, 0, 1, 2'd3, 4'h7, 7'h01, 7'h02, 0);
        // stray bytes and system common
        add(1, 8'h00, 0, 0, 0, 0, 0, 0, 0);
        add(0, 8'h12, 0, 0, 0, 0, 0, 0, 1);
        add(0, 8'hF0, 0, 0, 0, 0, 0, 0, 1);
        add(0, 8'h01, 0, 0, 0, 0, 0, 0, 2);
        add(0, 8'h02, 0, 0, 0, 0, 0, 0, 3);
        add(0, 8'hF7, 0, 0, 0, 0, 0, 0, 3);
        add(0, 8'h05, 0, 0, 0, 0, 0, 0, 4);
        add(0, 8'h90, 0, 0, 0, 0, 0, 0, 4);
        add(0, 8'h3C, 0, 0, 0, 0, 0, 0, 4);
        add(0, 8'hF2, 0, 0, 0, 0, 0, 0, 4);
        add(0, 8'h40, 0, 0, 0, 0, 0, 0, 5);
        add(0, 8'h9F, 0, 0, 0, 0, 0, 0, 5);
        add(0, 8'h3C, 0, 0, 0, 0, 0, 0, 5);
        add(0, 8'h00, 0, 1, 2'd1, 4'hF, 7'h3C, 7'h00, 5);
        // channel filter on the OMNI=0, CHANNEL=2 instance
        add(1, 8'h00, 1, 0, 0, 0, 0, 0, 0);
        add(0, 8'h95, 1, 0, 0, 0, 0, 0, 0);
        add(0, 8'h3C, 1, 0, 0, 0, 0, 0, 0);
        add(0, 8'h40, 1, 0, 0, 0, 0, 0, 0);
        add(0, 8'hE2, 1, 0, 0, 0, 0, 0, 0);
        add(0, 8'h00, 1, 0, 0, 0, 0, 0, 0);
        add(0, 8'h40, 1, 1, 2'd3, 4'h2, 7'h00, 7'h40, 0);

        foreach (vecs[n]) begin
            string tag;
            tag = $sformatf("vec%0d", n);
            if (vecs[n].rst) begin
                do_reset();
            end else begin
                send_byte(vecs[n].b);
                check_sel(tag, vecs[n].sel, vecs[n].v, vecs[n].t, vecs[n].c,
                          vecs[n].k, vecs[n].val, vecs[n].stray);
                @(negedge clk);
                chk({tag, " pulse_end"}, vecs[n].sel ? b_v : a_v, 1'b0);
            end
        end

        // back-to-back strobes, including one during event_valid
        do_reset();
        burst[0] = 8'hB0; burst[1] = 8'h07; burst[2] = 8'h55; burst[3] = 8'h08; burst[4] = 8'h09;
        burst_v[0] = 0; burst_v[1] = 0; burst_v[2] = 1; burst_v[3] = 0; burst_v[4] = 1;
        for (int i = 0; i < 5; i++) begin
            din = burst[i]; rdy = 1'b1;
            @(negedge clk);
            chk($sformatf("burst%0d valid", i), a_v, burst_v[i]);
            if (i == 2) begin
                chk("burst2 key", a_k, 7'h07);
                chk("burst2 value", a_val, 7'h55);
            end
        end
        rdy = 1'b0;
        chk("burst type", a_t, 2'd2);
        chk("burst key", a_k, 7'h08);
        chk("burst value", a_val, 7'h09);
        @(negedge clk);
        chk("burst pulse_end", a_v, 1'b0);

        // reset wins over a coincident strobe
        send_byte(8'h90);
        send_byte(8'h3C);
        din = 8'h64; rdy = 1'b1; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; rdy = 1'b0;
        clear_last();
        check_sel("rstcol", 1'b0, 1'b0, 2'd0, 4'd0, 7'd0, 7'd0, 8'd0);
        chk("rstcol state", a_dbg, 2'd0);
        send_byte(8'h64);
        check_sel("rstcol after", 1'b0, 1'b0, 2'd0, 4'd0, 7'd0, 7'd0, 8'd1);

        // saturation of the stray counter
        do_reset();
        for (int i = 0; i < 300; i++) begin
            send_byte(8'h05);
            if (i == 253) chk("sat 254", a_s, 8'd254);
            if (i == 254) chk("sat 255", a_s, 8'd255);
        end
        chk("sat hold", a_s, 8'd255);
        chk("sat no event", a_v, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
